// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and Gray/binary pointer conversions used by both
// the write and read sides of the dual-clock FIFO.
package fifo_pkg;

  localparam int unsigned DefAsize = 4;
  localparam int unsigned DefDsize = 8;

  // Callers zero-extend narrower pointers and truncate the result back to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin_conv
  import fifo_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o = W'(gray2bin(32'(gray_i)));
  end

endmodule

// File: rtl/rptr_empty_fwft.sv
// Read-side control of the dual-clock FIFO: binary/Gray read pointer, registered empty flag,
// occupancy level and a first-word-fall-through output register.
module rptr_empty_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned ASIZE     = DefAsize,
  parameter int unsigned DSIZE     = DefDsize,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [ASIZE:0]   WSR2_ptr,
  input  logic             rinc,
  input  logic [DSIZE-1:0] rdata_mem,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic [DSIZE-1:0] dout,
  output logic             dout_valid,
  output logic [ASIZE:0]   rlevel,
  output logic             ralmost_empty
);

  localparam int unsigned PW = ASIZE + 1;

  logic [PW-1:0]    rbin_q, rbin_d;
  logic [PW-1:0]    rgray_q, rgray_d;
  logic             rempty_q, rempty_d;
  logic [DSIZE-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic [PW-1:0]    level_q, level_d;
  logic             ae_q, ae_d;
  logic [PW-1:0]    wbin_s;
  logic             pop, fetch;

  gray2bin_conv #(
    .W(PW)
  ) u_wptr_conv (
    .gray_i(WSR2_ptr),
    .bin_o (wbin_s)
  );

  always_comb begin
    pop      = rinc & dvalid_q;
    // Pull a word whenever memory has one and the output register is, or is becoming, free.
    fetch    = ~rempty_q & (~dvalid_q | pop);
    rbin_d   = rbin_q + PW'(fetch);
    rgray_d  = PW'(bin2gray(32'(rbin_d)));
    rempty_d = (rgray_d == WSR2_ptr);
    level_d  = wbin_s - rbin_d;
    ae_d     = (32'(level_d) <= AE_THRESH);

    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    if (fetch) begin
      dout_d   = rdata_mem;
      dvalid_d = 1'b1;
    end else if (pop) begin
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      rempty_q <= rempty_d;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      level_q <= '0;
      ae_q    <= 1'b1;
    end else begin
      level_q <= level_d;
      ae_q    <= ae_d;
    end
  end

  assign raddr         = rbin_q[ASIZE-1:0];
  assign rptr          = rgray_q;
  assign rempty        = rempty_q;
  assign dout          = dout_q;
  assign dout_valid    = dvalid_q;
  assign rlevel        = level_q;
  assign ralmost_empty = ae_q;

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Self-checking bench for rptr_empty_fwft: directed scenarios plus a randomized phase, checked
// against a count-based model of the read side.
module tb_rptr_empty_fwft;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic [4:0] WSR2_ptr = '0;
  logic       rinc = 1'b0;
  logic [7:0] rdata_mem;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic [7:0] dout;
  logic       dout_valid;
  logic [4:0] rlevel;
  logic       ralmost_empty;

  logic [7:0] mem [16];

  int total = 0;
  int fails = 0;

  // Model: counts of words written (wb) and words fetched (r), both modulo 32.
  int         wb = 0;
  int         r = 0;
  logic       mvalid = 1'b0;
  logic       mempty = 1'b1;
  logic [7:0] mdout = '0;
  int         mlevel = 0;
  logic       mae = 1'b1;

  always #5 rclk = ~rclk;

  assign rdata_mem = mem[raddr];

  rptr_empty_fwft #(
    .ASIZE    (4),
    .DSIZE    (8),
    .AE_THRESH(2)
  ) dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .WSR2_ptr     (WSR2_ptr),
    .rinc         (rinc),
    .rdata_mem    (rdata_mem),
    .raddr        (raddr),
    .rptr         (rptr),
    .rempty       (rempty),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .rlevel       (rlevel),
    .ralmost_empty(ralmost_empty)
  );

  function automatic logic [4:0] gray5(input int b);
    int v;
    v = b % 32;
    return 5'(v ^ (v / 2));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    check({step, ".raddr"}, 32'(raddr), 32'(r % 16));
    check({step, ".rptr"}, 32'(rptr), 32'(gray5(r)));
    check({step, ".rempty"}, 32'(rempty), 32'(mempty));
    check({step, ".dout_valid"}, 32'(dout_valid), 32'(mvalid));
    check({step, ".dout"}, 32'(dout), 32'(mdout));
    check({step, ".rlevel"}, 32'(rlevel), 32'(mlevel));
    check({step, ".ralmost_empty"}, 32'(ralmost_empty), 32'(mae));
  endtask

  // Write one word into the bench memory and advance the synchronised write pointer.
  task automatic push(input logic [7:0] data);
    mem[wb % 16] = data;
    wb = (wb + 1) % 32;
  endtask

  function automatic int space();
    return 16 - ((wb - r + 32) % 32);
  endfunction

  task automatic tick(input string step, input logic inc);
    logic       pop, fetch;
    logic [7:0] head;
    int         rn;
    rinc     = inc;
    WSR2_ptr = gray5(wb);
    pop      = inc && mvalid;
    fetch    = !mempty && (!mvalid || pop);
    head     = mem[r % 16];
    rn       = (r + (fetch ? 1 : 0)) % 32;
    @(posedge rclk);
    #1;
    if (fetch) begin
      mdout  = head;
      mvalid = 1'b1;
    end else if (pop) begin
      mvalid = 1'b0;
    end
    mempty = (rn == wb);
    mlevel = (wb - rn + 32) % 32;
    mae    = (mlevel <= 2);
    r      = rn;
    check_all(step);
  endtask

  task automatic model_reset();
    wb = 0; r = 0; mvalid = 1'b0; mempty = 1'b1; mdout = '0; mlevel = 0; mae = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    // 1: reset state; pop requests while empty are ignored.
    #12;
    check_all("reset");
    @(negedge rclk);
    rrst_n = 1'b1;
    tick("idle_rinc", 1'b1);
    tick("idle_rinc", 1'b1);

    // 2: single word falls through after two edges and is held while rinc=0.
    push(8'hA5);
    tick("first_n", 1'b0);
    tick("first_n1", 1'b0);
    tick("first_n2", 1'b0);
    check("first_dout", 32'(dout), 32'hA5);
    tick("first_hold", 1'b0);
    tick("first_hold", 1'b0);

    // 3: burst of five words streamed back to back.
    for (int i = 1; i < 5; i++) push(8'(8'h10 + i));
    for (int i = 0; i < 8; i++) tick("burst", 1'b1);
    check("burst_rptr", 32'(rptr), 32'h07);

    // 4: pointer wrap through bin 16 and on to 20.
    while (wb != 16) push(8'($urandom));
    for (int i = 0; i < 16; i++) tick("to16", 1'b1);
    while (wb != 20) push(8'($urandom));
    for (int i = 0; i < 8; i++) tick("wrap", 1'b1);
    check("wrap_rptr", 32'(rptr), 32'h1E);

    // 5: full memory, then drain while tracking almost-empty.
    while (space() > 0) push(8'($urandom));
    tick("full", 1'b0);
    tick("full", 1'b0);
    tick("full_fetch", 1'b0);
    check("full_level", 32'(rlevel), 32'd15);
    for (int i = 0; i < 18; i++) tick("drain", 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (space() > 0 && ($urandom_range(0, 3) != 0)) push(8'($urandom));
      tick("rand", 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 24; i++) tick("flush", 1'b1);

    // 6: asynchronous reset mid-stream with a valid head and seven words in memory.
    while (space() > 8) push(8'($urandom));
    for (int i = 0; i < 4; i++) tick("prereset", 1'b0);
    check("prereset_level", 32'(rlevel), 32'd7);
    #2;
    rrst_n = 1'b0;
    #1;
    model_reset();
    WSR2_ptr = '0;
    rinc = 1'b0;
    check_all("async_reset");
    @(negedge rclk);
    rrst_n = 1'b1;
    tick("post_reset", 1'b1);
    push(8'h3C);
    for (int i = 0; i < 4; i++) tick("post_reset_word", 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
